md_led_driver: RTL and testbench

Output stage downstream of the dunc16 core on the Mojo board. It monitors the core's write-cycle strobes, captures the 16-bit memory-data bus (MD_OUT) at the end of each write, and time-multiplexes the captured word onto the 8 onboard LEDs. An optional status phase shows core timing/state bits. It replaces the constant LED pattern in the top level.

---
 rtl/md_led_driver.sv | 87 ++++++++
 tb/tb_md_led_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/md_led_driver.sv
// md_led_driver: captures dunc16 write data and time-multiplexes it onto 8 LEDs
// Optional STAT display phase is compiled in with `define LED_STATUS_EN.
module md_led_driver #(
    parameter int          DIV_W      = 24,
    parameter logic [15:0] RESET_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] md_out,
    input  logic        setwrite,
    input  logic        clrwrite,
    input  logic        t0,
    input  logic        t1,
    input  logic        execute,
    input  logic        i_sta,
    output logic [7:0]  led
);
    typedef enum logic {IDLE, WRITING} state_t;

    state_t         state;
    logic [15:0]    data_reg;
    logic [2:0]     wr_cnt;
    logic [DIV_W-1:0] presc;
    logic [7:0]     led_next;
    logic           capture;

`ifdef LED_STATUS_EN
    logic [1:0] phase;
`else
    logic       phase;
    logic       unused_status;
    assign unused_status = ^{execute, i_sta, t0, t1, wr_cnt};
`endif

    // A zero-length write (both strobes in IDLE) captures as well as a normal close.
    assign capture = clrwrite && (setwrite || state == WRITING);

    // Write-cycle FSM with data capture and write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= RESET_WORD;
            wr_cnt   <= 3'd0;
        end else begin
            if (capture) begin
                data_reg <= md_out;
                wr_cnt   <= wr_cnt + 3'd1;
            end
            case (state)
                IDLE:    if (setwrite && !clrwrite) state <= WRITING;
                WRITING: if (clrwrite) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running prescaler; the display phase advances on its wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            phase <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
`ifdef LED_STATUS_EN
            if (&presc) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
`else
            if (&presc) phase <= ~phase;
`endif
        end
    end

    // Select the LED source for the current phase
    always_comb begin
`ifdef LED_STATUS_EN
        led_next = (phase == 2'd2) ? {execute, i_sta, t0, t1, state == WRITING, wr_cnt}
                 : phase[0] ? data_reg[15:8] : data_reg[7:0];
`else
        led_next = phase ? data_reg[15:8] : data_reg[7:0];
`endif
    end

    // Registered LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= RESET_WORD[7:0];
        else        led <= led_next;
    end
endmodule

// File: tb/tb_md_led_driver.sv
// tb_md_led_driver: directed self-checking bench for md_led_driver (DIV_W=4)
module tb_md_led_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] md_out = 16'h0000;
    logic        setwrite = 1'b0;
    logic        clrwrite = 1'b0;
    logic        t0 = 1'b1;
    logic        t1 = 1'b0;
    logic        execute = 1'b1;
    logic        i_sta = 1'b0;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;
    int n = 0;

    md_led_driver #(.DIV_W(4), .RESET_WORD(16'hA5C3)) dut (
        .clk(clk), .rst_n(rst_n), .md_out(md_out), .setwrite(setwrite),
        .clrwrite(clrwrite), .t0(t0), .t1(t1), .execute(execute),
        .i_sta(i_sta), .led(led)
    );

    always #5 clk = ~clk;

    // advance one clock edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (led === exp)
        else begin
            errors++;
            $error("FAIL %s: led=%h expected %h (edge %0d)", tag, led, exp, n);
        end
    endtask

    initial begin
        // reset held
        tick();
        tick();
        chk("reset_hold", 8'hC3);
        rst_n = 1'b1;
        n = 0;
        run_to(16);
        chk("lo_before_wrap", 8'hC3);
        tick();
        chk("hi_after_wrap", 8'hA5);

        // reset in the middle of an open write cycle
        setwrite = 1'b1;
        tick();
        setwrite = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 8'hC3);
        tick();
        rst_n = 1'b1;
        n = 0;
        clrwrite = 1'b1;
        md_out = 16'hFFFF;
        tick();
        clrwrite = 1'b0;
        tick();
        chk("abandoned_write", 8'hC3);

        // normal write: setwrite, two idle cycles, clrwrite
        setwrite = 1'b1;
        tick();
        setwrite = 1'b0;
        tick();
        tick();
        clrwrite = 1'b1;
        md_out = 16'h1234;
        tick();
        clrwrite = 1'b0;
        chk("capture_edge", 8'hC3);
        tick();
        chk("normal_lo", 8'h34);

        // lone clrwrite is ignored
        clrwrite = 1'b1;
        md_out = 16'hFFFF;
        tick();
        clrwrite = 1'b0;
        tick();
        chk("lone_clr", 8'h34);

        // zero-length write captures and stays IDLE
        setwrite = 1'b1;
        clrwrite = 1'b1;
        md_out = 16'h00FF;
        tick();
        setwrite = 1'b0;
        clrwrite = 1'b0;
        tick();
        chk("zero_len", 8'hFF);
        clrwrite = 1'b1;
        md_out = 16'hAAAA;
        tick();
        clrwrite = 1'b0;
        tick();
        chk("zero_len_idle", 8'hFF);

        // back-to-back writes across the LO->HI wrap
        setwrite = 1'b1;
        tick();
        setwrite = 1'b0;
        clrwrite = 1'b1;
        md_out = 16'hBEEF;
        tick();
        clrwrite = 1'b0;
        setwrite = 1'b1;
        tick();
        chk("b2b_lo", 8'hEF);
        setwrite = 1'b0;
        clrwrite = 1'b1;
        md_out = 16'hC0DE;
        tick();
        clrwrite = 1'b0;
        chk("b2b_hi_first", 8'hBE);
        tick();
        chk("b2b_hi_second", 8'hC0);

        run_to(32);
        chk("hi_end", 8'hC0);
        tick();
`ifdef LED_STATUS_EN
        // STAT phase: execute=1 i_sta=0 t0=1 t1=0 idle, four captures so far
        chk("stat_cnt4", 8'hA4);
        for (int i = 1; i <= 5; i++) begin
            setwrite = 1'b1;
            tick();
            setwrite = 1'b0;
            clrwrite = 1'b1;
            md_out = 16'(i * 16'h1111);
            tick();
            clrwrite = 1'b0;
        end
        tick();
        chk("stat_wrap", 8'hA1);
        setwrite = 1'b1;
        tick();
        setwrite = 1'b0;
        tick();
        chk("stat_writing", 8'hA9);
        clrwrite = 1'b1;
        md_out = 16'h1357;
        tick();
        clrwrite = 1'b0;
        run_to(48);
        chk("stat_end", 8'hA2);
        tick();
        chk("lo_after_stat", 8'h57);
`else
        chk("lo_second", 8'hDE);
        run_to(49);
        chk("hi_second", 8'hC0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
